arc4_dropn_core: RTL and testbench
==================================

# arc4_dropn_core

Parametrised ARC4 decryption engine: successor to the fixed 3-byte-key task3 datapath. It runs the full ARC4 sequence over external single-port RAMs: S-box init, key scheduling, optional RC4-drop[N] keystream discard, then length-prefixed message decryption. It is instantiated under the board top level between the ct ROM, the S RAM and the pt RAM. Completion is signalled on rdy/en.

## Interface
- KEY_BYTES, 3, key length in bytes (1..32)
- DROP_N, 0, keystream bytes discarded after KSA (0..1024)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request, accepted only when rdy=1
- rdy  out  1  1 = idle, ready for en
- key  in  8*KEY_BYTES  key; byte 0 = bits [8*KEY_BYTES-1 -: 8]; sampled on accepting edge
- s_addr  out  8  S RAM address
- s_wrdata  out  8  S RAM write data
- s_wren  out  1  S RAM write enable
- s_rddata  in  8  S RAM read data, valid one cycle after s_addr
- ct_addr  out  8  ct ROM address
- ct_rddata  in  8  ct read data, valid one cycle after ct_addr
- pt_addr  out  8  pt RAM address
- pt_wrdata  out  8  pt write data
- pt_wren  out  1  pt write enable

## Operation
- Reset: rdy=1; all addrs/wrdata 0; s_wren=pt_wren=0; FSM IDLE; i, j, k, key index 0.
- IDLE: rdy=1, all wren 0. An en=1 edge latches key, clears i/j, enters INIT, and drops rdy the next cycle. en while rdy=0 is ignored.
- INIT: one write per cycle, S[i]=i, for i=0..255. Takes 256 cycles.
- KSA: 6 cycles per i, for i=0..255.
  - KR_I: s_addr=i.
  - KW_I: wait.
  - KR_J: si=s_rddata; j=j+si+key[i mod KEY_BYTES]; s_addr=j.
  - KW_J: wait.
  - KS_I: sj=s_rddata; write S[i]=sj.
  - KS_J: write S[j]=si; i++.
  - Key index uses a wrapping counter, not a modulo.
- LEN: LR drives ct_addr=0. LC captures L=ct_rddata and writes pt[0]=L. Then i=j=0. Takes 2 cycles.
- DROP: DROP_N iterations of the PRGA swap only. Each is 6 cycles: i++, read S[i], j+=si, read S[j], write both. There is no ct/pt access. Drop runs even when L=0.
- PRGA: for k=1..L, 9 cycles each.
  - The 6 swap cycles, as in DROP.
  - PR_K: s_addr=si+sj; ct_addr=k.
  - PW_K: wait.
  - PO: pt_addr=k; pt_wrdata=s_rddata^ct_rddata; pt_wren=1.
- DONE: back to IDLE; rdy=1.
- Arithmetic: i, j, si+sj and j+si+key are all mod 256 (8-bit wrap). k is 8-bit and L≤255, so k never wraps.
- L=0: pt[0]=0 is written, no pt[1..] writes occur, and the block returns to IDLE after DROP.
- rst mid-operation: on the next edge, IDLE, rdy=1, wren 0. S/pt contents are undefined and not restored.
- en and rst asserted together: rst wins.

## Timing
- S and ct reads: 1-cycle latency. The FSM never uses read data in the cycle its address is driven.
- At most one S access per cycle (single port). s_wren is never high in a read-address cycle of the same port.
- Latency from the accepting en edge to rdy=1 is exactly 256+1536+2+6·DROP_N+9·L cycles.
- pt_wren is high for exactly 1+L cycles per run, each time at a distinct address.
- rdy is low for the entire run, with no glitch between phases.

## Structure
- Package arc4_pkg holds:
  - state enum: IDLE, INIT, KR_I, KW_I, KR_J, KW_J, KS_I, KS_J, LR, LC, swap states, PR_K, PW_K, PO, DONE;
  - a phase flag (KSA/DROP/PRGA) that reuses the swap states;
  - S_DEPTH=256.
- Sub-module key_byte_sel: a combinational mux selecting byte n of the KEY_BYTES-wide key. It is parametrised on KEY_BYTES.
- The FSM and datapath live in one module. The RAMs stay outside.

## Test plan
- KEY_BYTES=3, DROP_N=0, key=24'h4B6579 ("Key"), ct = 09 BB F3 16 E8 D9 40 AF 0A D3 → pt = 09 50 6C 61 69 6E 74 65 78 74. rdy rises exactly 1875 cycles after en.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"), ct = 05 10 21 BF 04 20 → pt = 05 70 65 64 69 61 ("pedia").
- KEY_BYTES=3, DROP_N=1, key=24'h4B6579, ct = 02 9F 77 → pt = 02 00 00. Latency is 256+1536+2+6+18 = 1818 cycles.
- L=0 (ct[0]=00): exactly one pt write, pt[0]=00. rdy returns after 1794 cycles.
- Assert rst during KSA (cycle 500): rdy=1 and all wren 0 on the next edge. A new en with the "Key" vector then reproduces test 1 exactly.
- Pulse en repeatedly while rdy=0: no restart, latency unchanged. Back-to-back runs with different keys both decrypt correctly.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 drop-N engine: FSM state encoding, swap-phase flag, S-box geometry.
package arc4_pkg;

  localparam int S_DEPTH = 256;

  typedef enum logic [4:0] {
    IDLE, INIT,
    KR_I, KW_I, KR_J, KW_J, KS_I, KS_J,
    LR, LC,
    SW_I, SW_IW, SW_J, SW_JW, SW_WI, SW_WJ,
    PR_K, PW_K, PO,
    DONE
  } state_t;

  // Selects what follows a swap: another discard, or a keystream output.
  typedef enum logic [1:0] {
    PH_KSA, PH_DROP, PH_PRGA
  } phase_t;

  function automatic logic is_last_index(input logic [7:0] v);
    return v == 8'(S_DEPTH - 1);
  endfunction

endpackage

// File: rtl/key_byte_sel.sv
// Combinational mux returning byte n of a KEY_BYTES-wide key; byte 0 is the most significant.
module key_byte_sel #(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1
) (
  input  logic [8*KEY_BYTES-1:0] key_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [7:0]             byte_o
);

  always_comb begin
    byte_o = 8'd0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      byte_o = (idx_i == IDX_W'(n)) ? key_i[8*(KEY_BYTES-1-n) +: 8] : byte_o;
    end
  end

endmodule

// File: rtl/arc4_dropn_core.sv
// ARC4 decryption engine over external S/ct/pt memories: init, KSA, drop-N discard, PRGA.
// All memory-side outputs are registered and reflect the state being entered.
module arc4_dropn_core
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam int              IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [10:0]     DROP_W    = 11'(DROP_N);
  localparam logic [IDX_W-1:0] KIDX_LAST = IDX_W'(KEY_BYTES - 1);

  state_t                 state_q;
  phase_t                 phase_q;
  logic                   rdy_q;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [7:0]             i_q, j_q, si_q, sj_q, k_q, len_q;
  logic [IDX_W-1:0]       kidx_q;
  logic [10:0]            drop_cnt_q;
  logic [7:0]             s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q, pt_wrdata_q;
  logic                   s_wren_q, pt_wren_q;

  logic [7:0] key_byte_s, i_inc_d, j_ksa_d, j_prga_d, out_addr_d;

  key_byte_sel #(.KEY_BYTES(KEY_BYTES), .IDX_W(IDX_W)) u_key_sel (
    .key_i  (key_q),
    .idx_i  (kidx_q),
    .byte_o (key_byte_s)
  );

  assign i_inc_d    = i_q + 8'd1;
  assign j_ksa_d    = j_q + s_rddata + key_byte_s;
  assign j_prga_d   = j_q + s_rddata;
  assign out_addr_d = si_q + sj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= PH_KSA;
      rdy_q       <= 1'b1;
      key_q       <= '0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      k_q         <= 8'd0;
      len_q       <= 8'd0;
      kidx_q      <= '0;
      drop_cnt_q  <= 11'd0;
      s_addr_q    <= 8'd0;
      s_wrdata_q  <= 8'd0;
      s_wren_q    <= 1'b0;
      ct_addr_q   <= 8'd0;
      pt_addr_q   <= 8'd0;
      pt_wrdata_q <= 8'd0;
      pt_wren_q   <= 1'b0;
    end else begin
      s_wren_q  <= 1'b0;
      pt_wren_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          if (en) begin
            key_q      <= key;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            kidx_q     <= '0;
            phase_q    <= PH_KSA;
            ct_addr_q  <= 8'd0;
            s_addr_q   <= 8'd0;
            s_wrdata_q <= 8'd0;
            s_wren_q   <= 1'b1;
            rdy_q      <= 1'b0;
            state_q    <= INIT;
          end
        end
        INIT: begin
          if (is_last_index(i_q)) begin
            i_q      <= 8'd0;
            s_addr_q <= 8'd0;
            state_q  <= KR_I;
          end else begin
            i_q        <= i_inc_d;
            s_addr_q   <= i_inc_d;
            s_wrdata_q <= i_inc_d;
            s_wren_q   <= 1'b1;
          end
        end
        KR_I: state_q <= KW_I;
        KW_I: begin
          si_q     <= s_rddata;
          j_q      <= j_ksa_d;
          s_addr_q <= j_ksa_d;
          state_q  <= KR_J;
        end
        KR_J: state_q <= KW_J;
        KW_J: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= KS_I;
        end
        KS_I: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= KS_J;
        end
        KS_J: begin
          i_q      <= i_inc_d;
          s_addr_q <= i_inc_d;
          kidx_q   <= (kidx_q == KIDX_LAST) ? '0 : kidx_q + IDX_W'(1);
          state_q  <= is_last_index(i_q) ? LR : KR_I;
        end
        // ct_addr has sat at 0 since the start, so byte 0 is already on ct_rddata.
        LR: begin
          len_q       <= ct_rddata;
          pt_addr_q   <= 8'd0;
          pt_wrdata_q <= ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= LC;
        end
        LC: begin
          j_q        <= 8'd0;
          k_q        <= 8'd1;
          drop_cnt_q <= 11'd0;
          i_q        <= 8'd1;
          s_addr_q   <= 8'd1;
          if (DROP_W != 11'd0) begin
            phase_q <= PH_DROP;
            state_q <= SW_I;
          end else if (len_q != 8'd0) begin
            phase_q <= PH_PRGA;
            state_q <= SW_I;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        SW_I: state_q <= SW_IW;
        SW_IW: begin
          si_q     <= s_rddata;
          j_q      <= j_prga_d;
          s_addr_q <= j_prga_d;
          state_q  <= SW_J;
        end
        SW_J: state_q <= SW_JW;
        SW_JW: begin
          sj_q       <= s_rddata;
          s_addr_q   <= i_q;
          s_wrdata_q <= s_rddata;
          s_wren_q   <= 1'b1;
          state_q    <= SW_WI;
        end
        SW_WI: begin
          s_addr_q   <= j_q;
          s_wrdata_q <= si_q;
          s_wren_q   <= 1'b1;
          state_q    <= SW_WJ;
        end
        SW_WJ: begin
          if (phase_q == PH_PRGA) begin
            s_addr_q  <= out_addr_d;
            ct_addr_q <= k_q;
            state_q   <= PR_K;
          end else if (drop_cnt_q + 11'd1 != DROP_W) begin
            drop_cnt_q <= drop_cnt_q + 11'd1;
            i_q        <= i_inc_d;
            s_addr_q   <= i_inc_d;
            state_q    <= SW_I;
          end else if (len_q != 8'd0) begin
            phase_q  <= PH_PRGA;
            i_q      <= i_inc_d;
            s_addr_q <= i_inc_d;
            state_q  <= SW_I;
          end else begin
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        PR_K: state_q <= PW_K;
        PW_K: begin
          pt_addr_q   <= k_q;
          pt_wrdata_q <= s_rddata ^ ct_rddata;
          pt_wren_q   <= 1'b1;
          state_q     <= PO;
        end
        PO: begin
          if (k_q == len_q) begin
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q      <= k_q + 8'd1;
            i_q      <= i_inc_d;
            s_addr_q <= i_inc_d;
            state_q  <= SW_I;
          end
        end
        default: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdy       = rdy_q;
  assign s_addr    = s_addr_q;
  assign s_wrdata  = s_wrdata_q;
  assign s_wren    = s_wren_q;
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_arc4_dropn_core.sv
// Bench for arc4_dropn_core: three instances (3-byte key, 4-byte key, 3-byte key with drop 1)
// driven with directed vectors and random messages, checked against a plain RC4 reference.
module tb_arc4_dropn_core;

  localparam int NI = 3;
  localparam int KB [NI] = '{3, 4, 3};
  localparam int DR [NI] = '{0, 0, 1};

  logic clk, rst;
  logic [NI-1:0]        en_v, rdy_v, s_wren_v, pt_wren_v, clr_v;
  logic [NI-1:0][255:0] key_v;
  logic [NI-1:0][7:0]   s_addr_v, s_wrdata_v, s_rd_v, ct_addr_v, ct_rd_v, pt_addr_v, pt_wrdata_v;

  logic [7:0]   s_mem  [NI][256];
  logic [7:0]   ct_mem [NI][256];
  logic [7:0]   pt_mem [NI][256];
  logic [255:0] pt_seen [NI];
  int           pt_cnt [NI];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    arc4_dropn_core #(.KEY_BYTES(KB[g]), .DROP_N(DR[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en_v[g]),
      .rdy       (rdy_v[g]),
      .key       (key_v[g][8*KB[g]-1:0]),
      .s_addr    (s_addr_v[g]),
      .s_wrdata  (s_wrdata_v[g]),
      .s_wren    (s_wren_v[g]),
      .s_rddata  (s_rd_v[g]),
      .ct_addr   (ct_addr_v[g]),
      .ct_rddata (ct_rd_v[g]),
      .pt_addr   (pt_addr_v[g]),
      .pt_wrdata (pt_wrdata_v[g]),
      .pt_wren   (pt_wren_v[g])
    );
  end

  always #5 clk = ~clk;

  // Synchronous memories with one-cycle read latency, plus pt write bookkeeping.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (s_wren_v[g]) s_mem[g][s_addr_v[g]] <= s_wrdata_v[g];
      s_rd_v[g]  <= s_mem[g][s_addr_v[g]];
      ct_rd_v[g] <= ct_mem[g][ct_addr_v[g]];
      if (clr_v[g]) begin
        pt_cnt[g]  <= 0;
        pt_seen[g] <= '0;
      end else if (pt_wren_v[g]) begin
        pt_mem[g][pt_addr_v[g]]  <= pt_wrdata_v[g];
        pt_cnt[g]                <= pt_cnt[g] + 1;
        pt_seen[g][pt_addr_v[g]] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Textbook RC4 with drop-N; pt[0] is the length byte copied through.
  function automatic void rc4_ref(input logic [255:0] k, input int klen, input int drop,
                                  input int len, input logic [7:0] ct [256],
                                  output logic [7:0] pt [256]);
    int s [256];
    int i, j, t;
    for (int n = 0; n < 256; n++) begin
      s[n]  = n;
      pt[n] = 8'h00;
    end
    j = 0;
    for (i = 0; i < 256; i++) begin
      j = (j + s[i] + int'(k[8*(klen-1-(i % klen)) +: 8])) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int d = 0; d < drop; d++) begin
      i = (i + 1) % 256; j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    pt[0] = ct[0];
    for (int n = 1; n <= len; n++) begin
      i = (i + 1) % 256; j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      pt[n] = ct[n] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  task automatic load_ct(input int g, input logic [7:0] ctq [$], output logic [7:0] ctarr [256]);
    for (int n = 0; n < 256; n++) begin
      ctarr[n]     = (n < ctq.size()) ? ctq[n] : 8'($urandom);
      ct_mem[g][n] = ctarr[n];
    end
  endtask

  task automatic run(input int g, input logic [255:0] k, input logic [7:0] ctq [$],
                     input logic [7:0] expq [$], input bit spam, input string tag);
    logic [7:0] ctarr [256];
    logic [7:0] ref_pt [256];
    int len, lat;
    bit done;
    load_ct(g, ctq, ctarr);
    len = int'(ctarr[0]);
    clr_v[g] = 1'b1;
    @(posedge clk); #1;
    clr_v[g] = 1'b0;
    key_v[g] = k;
    en_v[g]  = 1'b1;
    @(posedge clk); #1;
    en_v[g]  = 1'b0;
    key_v[g] = {8{$urandom}};
    lat = 0;
    done = 1'b0;
    while (!done && lat < 6000) begin
      @(posedge clk); #1;
      lat++;
      if (rdy_v[g]) done = 1'b1;
      else if (spam) en_v[g] = 1'($urandom);
    end
    en_v[g] = 1'b0;
    check({tag, " latency"}, lat, 1794 + 6*DR[g] + 9*len);
    rc4_ref(k, KB[g], DR[g], len, ctarr, ref_pt);
    check({tag, " pt write count"}, pt_cnt[g], len + 1);
    check({tag, " pt distinct addrs"}, $countones(pt_seen[g]), len + 1);
    for (int n = 0; n <= len; n++) begin
      check($sformatf("%s pt[%0d] model", tag, n), pt_mem[g][n], ref_pt[n]);
      if (n < expq.size()) check($sformatf("%s pt[%0d] vector", tag, n), pt_mem[g][n], expq[n]);
    end
  endtask

  task automatic run_random(input int g, input string tag);
    logic [7:0] ctq [$];
    logic [7:0] none [$];
    int len;
    len = $urandom_range(0, 24);
    ctq.push_back(8'(len));
    for (int n = 0; n < len; n++) ctq.push_back(8'($urandom));
    run(g, {8{$urandom}}, ctq, none, 1'b0, tag);
  endtask

  logic [7:0] ct1 [$], pt1 [$], ct2 [$], pt2 [$], ct3 [$], pt3 [$], ct0 [$], pt0 [$];
  logic [7:0] scratch [256];

  initial begin
    clk = 1'b0; rst = 1'b1; en_v = '0; clr_v = '0; key_v = '0;
    for (int g = 0; g < NI; g++)
      for (int n = 0; n < 256; n++) ct_mem[g][n] = 8'h00;
    ct1 = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    pt1 = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct2 = '{8'h05, 8'h10, 8'h21, 8'hBF, 8'h04, 8'h20};
    pt2 = '{8'h05, 8'h70, 8'h65, 8'h64, 8'h69, 8'h61};
    ct3 = '{8'h02, 8'h9F, 8'h77};
    pt3 = '{8'h02, 8'h00, 8'h00};
    ct0 = '{8'h00};
    pt0 = '{8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("reset rdy", 32'(rdy_v), 32'h7);
    check("reset s_wren", 32'(s_wren_v), 32'h0);
    check("reset pt_wren", 32'(pt_wren_v), 32'h0);
    check("reset s_addr", 32'(s_addr_v), 32'h0);
    check("reset s_wrdata", 32'(s_wrdata_v), 32'h0);
    check("reset ct_addr", 32'(ct_addr_v), 32'h0);
    check("reset pt_addr", 32'(pt_addr_v), 32'h0);
    check("reset pt_wrdata", 32'(pt_wrdata_v), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(0, 256'h4B6579, ct1, pt1, 1'b0, "key3");
    run(1, 256'h57696B69, ct2, pt2, 1'b0, "wiki");
    run(2, 256'h4B6579, ct3, pt3, 1'b0, "drop1");
    run(0, 256'h4B6579, ct0, pt0, 1'b0, "len0");
    run(2, 256'h4B6579, ct0, pt0, 1'b0, "drop1 len0");

    // Reset partway through KSA, then the same vector must decrypt identically.
    load_ct(0, ct1, scratch);
    key_v[0] = 256'h4B6579;
    en_v[0]  = 1'b1;
    @(posedge clk); #1;
    en_v[0] = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    check("midrun rdy low", 32'(rdy_v[0]), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrun rst rdy", 32'(rdy_v[0]), 32'h1);
    check("midrun rst s_wren", 32'(s_wren_v[0]), 32'h0);
    check("midrun rst pt_wren", 32'(pt_wren_v[0]), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    run(0, 256'h4B6579, ct1, pt1, 1'b0, "after rst");

    run(0, 256'h4B6579, ct1, pt1, 1'b1, "en spam");
    run(1, 256'h57696B69, ct2, pt2, 1'b1, "wiki spam");
    run_random(1, "b2b rand");

    for (int r = 0; r < 2; r++) begin
      for (int g = 0; g < NI; g++) run_random(g, $sformatf("rand g%0d r%0d", g, r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
